// File: rtl/core_ctrl_if.sv
// Host/core-side bundle of the conv sequencer: start/abort in, inst word and SFU/status strobes out.
// The sequencer binds to the slave modport; the host (or bench) uses master.
interface core_ctrl_if;
  logic        start;
  logic        abort;
  logic [33:0] inst;
  logic        acc_clr;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, abort,
    input  inst, acc_clr, out_valid, out_idx, busy, done
  );

  modport slave (
    input  start, abort,
    output inst, acc_clr, out_valid, out_idx, busy, done
  );
endinterface

// File: rtl/core_ctrl.sv
// Sequencer for the 2D-conv core: per kernel position it streams weights and activations
// through L0/PE and dumps OFIFO to pmem, then accumulates every output pixel through the SFU.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | waiting for start, inst idle
//  S_W_L0   | read COL weight words from xmem into L0
//  S_W_LOAD | L0 -> PE kernel load
//  S_GAP    | settle gap after kernel load
//  S_A_L0   | read LEN_NIJ activation words from xmem into L0
//  S_EXEC   | stream activations through the array
//  S_DRAIN  | wait for partial sums to reach OFIFO
//  S_OF_RD  | OFIFO -> pmem (write lags the read by one cycle)
//  S_ACC    | per output pixel: clear, LEN_KIJ pmem reads, acc, out_valid
//  S_FIN    | one-cycle done pulse
module core_ctrl #(
  parameter int COL     = 8,
  parameter int IN_W    = 6,
  parameter int K       = 3,
  parameter int GAP_CYC = 10,
  parameter int DRAIN   = 36,
  parameter int WBASE   = 1024
) (
  input logic        clk,
  input logic        reset,
  core_ctrl_if.slave bus
);
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K * K;
  localparam int OUT_W    = IN_W - K + 1;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int ACC_LEN  = LEN_KIJ + 3;
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC, S_DRAIN, S_OF_RD, S_ACC, S_FIN
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  tmr, tmr_nx;
  logic [3:0]  kij, kij_nx;
  logic [3:0]  oidx, oidx_nx;
  int          sub_cur, sub_nx;

  logic        acc_b, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, exec_b, load_b;
  logic [10:0] a_p, a_x;
  logic [33:0] inst_nx;
  logic        acc_clr_nx, out_valid_nx, busy_nx, done_nx;
  logic [3:0]  out_idx_nx;

  // psum of output pixel o for kernel position k lives at k*LEN_NIJ + input-pixel index
  function automatic logic [10:0] acc_addr(input logic [3:0] o, input logic [3:0] k);
    int ai;
    ai = int'(k) * LEN_NIJ + (int'(o) / OUT_W + int'(k) / K) * IN_W
         + int'(o) % OUT_W + int'(k) % K;
    return 11'(ai);
  endfunction

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    kij_nx   = kij;
    oidx_nx  = oidx;
    if (tmr != '0) tmr_nx = tmr - 8'd1;

    case (state)
      S_IDLE: if (bus.start) begin
        state_nx = S_W_L0;
        tmr_nx   = 8'(COL - 1);
        kij_nx   = '0;
      end
      S_W_L0:   if (tmr == '0) begin state_nx = S_W_LOAD; tmr_nx = 8'(COL - 1);     end
      S_W_LOAD: if (tmr == '0) begin state_nx = S_GAP;    tmr_nx = 8'(GAP_CYC - 1); end
      S_GAP:    if (tmr == '0) begin state_nx = S_A_L0;   tmr_nx = 8'(LEN_NIJ - 1); end
      S_A_L0:   if (tmr == '0) begin state_nx = S_EXEC;   tmr_nx = 8'(LEN_NIJ - 1); end
      S_EXEC:   if (tmr == '0) begin state_nx = S_DRAIN;  tmr_nx = 8'(DRAIN - 1);   end
      S_DRAIN:  if (tmr == '0) begin state_nx = S_OF_RD;  tmr_nx = 8'(LEN_NIJ - 1); end
      S_OF_RD: if (tmr == '0) begin
        if (kij == 4'(LEN_KIJ - 1)) begin
          state_nx = S_ACC;
          tmr_nx   = 8'(ACC_LEN - 1);
          oidx_nx  = '0;
        end else begin
          state_nx = S_W_L0;
          tmr_nx   = 8'(COL - 1);
          kij_nx   = kij + 4'd1;
        end
      end
      S_ACC: if (tmr == '0) begin
        if (oidx == 4'(LEN_ONIJ - 1)) begin
          state_nx = S_FIN;
        end else begin
          oidx_nx = oidx + 4'd1;
          tmr_nx  = 8'(ACC_LEN - 1);
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (bus.abort) begin
      state_nx = S_IDLE;
      tmr_nx   = '0;
      kij_nx   = '0;
      oidx_nx  = '0;
    end

    sub_cur = ACC_LEN - 1 - int'(tmr);
    sub_nx  = ACC_LEN - 1 - int'(tmr_nx);

    acc_b = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = '0;
    cen_x = 1'b1; wen_x = 1'b1; a_x = '0;
    ofifo_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; exec_b = 1'b0; load_b = 1'b0;
    acc_clr_nx = 1'b0; out_valid_nx = 1'b0; out_idx_nx = '0;

    // Strobes that trail the current cycle's SRAM/OFIFO read; an abort drops them.
    if (!bus.abort) begin
      case (state)
        S_W_L0, S_A_L0: l0_wr = 1'b1;
        S_OF_RD: begin
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = 11'(int'(kij) * LEN_NIJ + LEN_NIJ - 1 - int'(tmr));
        end
        S_ACC: begin
          if (sub_cur >= 1 && sub_cur <= LEN_KIJ) acc_b = 1'b1;
          if (sub_cur == LEN_KIJ + 1) begin
            out_valid_nx = 1'b1;
            out_idx_nx   = oidx;
          end
        end
        default: ;
      endcase
    end

    case (state_nx)
      S_W_L0: begin
        cen_x = 1'b0;
        a_x   = 11'(WBASE + int'(kij_nx) * COL + COL - 1 - int'(tmr_nx));
      end
      S_W_LOAD: begin l0_rd = 1'b1; load_b = 1'b1; end
      S_A_L0: begin
        cen_x = 1'b0;
        a_x   = 11'(LEN_NIJ - 1 - int'(tmr_nx));
      end
      S_EXEC:  begin l0_rd = 1'b1; exec_b = 1'b1; end
      S_OF_RD: ofifo_rd = 1'b1;
      S_ACC: begin
        if (sub_nx == 0) begin
          acc_clr_nx = 1'b1;
        end else if (sub_nx <= LEN_KIJ) begin
          cen_p = 1'b0;
          wen_p = 1'b1;
          a_p   = acc_addr(oidx_nx, 4'(sub_nx - 1));
        end
      end
      default: ;
    endcase

    inst_nx = {acc_b, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
               ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, exec_b, load_b};
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      tmr           <= '0;
      kij           <= '0;
      oidx          <= '0;
      bus.inst      <= INST_IDLE;
      bus.acc_clr   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nx;
      tmr           <= tmr_nx;
      kij           <= kij_nx;
      oidx          <= oidx_nx;
      bus.inst      <= inst_nx;
      bus.acc_clr   <= acc_clr_nx;
      bus.out_valid <= out_valid_nx;
      bus.out_idx   <= out_idx_nx;
      bus.busy      <= busy_nx;
      bus.done      <= done_nx;
    end
  end
endmodule
